// File: rtl/apb_arbiter.sv
// Two-requester APB master: round-robin grant, SETUP/ACCESS sequencing,
// per-port done/rdata/err return and a watchdog that ends a stalled ACCESS.
module apb_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  APB_PCLK,
  input  logic                  APB_PRESET,
  input  logic                  m0_req,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  input  logic                  m0_write,
  input  logic [3:0]            m0_strb,
  output logic                  m0_done,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_err,
  input  logic                  m1_req,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  input  logic                  m1_write,
  input  logic [3:0]            m1_strb,
  output logic                  m1_done,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_err,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pdata,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [3:0]            pstb,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  ready,
  input  logic                  perr
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam int unsigned CNT_WIDTH =
    (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_VAL = CNT_WIDTH'(TIMEOUT_CYCLES);

  logic [1:0]           state_reg;
  logic                 last_grant_reg;
  logic                 grant_reg;
  logic [CNT_WIDTH-1:0] wait_cnt_reg;

  logic                  win_m1;
  logic                  timeout_hit;
  logic                  finish;
  logic [DATA_WIDTH-1:0] cap_rdata;
  logic                  cap_err;

  always_comb begin
    // On a tie the port that did not win last time takes the bus.
    win_m1      = m1_req & (~m0_req | ~last_grant_reg);
    timeout_hit = (TIMEOUT_CYCLES != 0) && ((wait_cnt_reg + 1'b1) == TIMEOUT_VAL);
    finish      = ready | timeout_hit;
    cap_rdata   = '0;
    cap_err     = 1'b1;
    if (ready) begin
      cap_rdata = pwrite ? '0 : prdata;
      cap_err   = perr;
    end
  end

  always_ff @(posedge APB_PCLK or posedge APB_PRESET) begin
    if (APB_PRESET) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      grant_reg      <= 1'b0;
      wait_cnt_reg   <= '0;
      paddr          <= '0;
      pdata          <= '0;
      psel           <= 1'b0;
      penable        <= 1'b0;
      pwrite         <= 1'b0;
      pstb           <= 4'h0;
      m0_done        <= 1'b0;
      m0_rdata       <= '0;
      m0_err         <= 1'b0;
      m1_done        <= 1'b0;
      m1_rdata       <= '0;
      m1_err         <= 1'b0;
    end else begin
      m0_done <= 1'b0;
      m1_done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (m0_req | m1_req) begin
            grant_reg      <= win_m1;
            last_grant_reg <= win_m1;
            paddr          <= win_m1 ? m1_addr  : m0_addr;
            pdata          <= win_m1 ? m1_wdata : m0_wdata;
            pwrite         <= win_m1 ? m1_write : m0_write;
            if (win_m1) pstb <= m1_write ? m1_strb : 4'h0;
            else        pstb <= m0_write ? m0_strb : 4'h0;
            psel           <= 1'b1;
            state_reg      <= SETUP;
          end
        end
        SETUP: begin
          penable      <= 1'b1;
          wait_cnt_reg <= '0;
          state_reg    <= ACCESS;
        end
        ACCESS: begin
          if (finish) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            state_reg <= DONE;
            if (grant_reg) begin
              m1_done  <= 1'b1;
              m1_rdata <= cap_rdata;
              m1_err   <= cap_err;
            end else begin
              m0_done  <= 1'b1;
              m0_rdata <= cap_rdata;
              m0_err   <= cap_err;
            end
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_arbiter.sv
// Directed bench for apb_arbiter with a one-wait-state APB slave model.
module tb_apb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 0, m1_req = 0;
  logic [31:0] m0_addr = 0, m1_addr = 0, m0_wdata = 0, m1_wdata = 0;
  logic        m0_write = 0, m1_write = 0;
  logic [3:0]  m0_strb = 0, m1_strb = 0;
  logic        m0_done, m1_done, m0_err, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] paddr, pdata, prdata = 0;
  logic        psel, penable, pwrite, perr = 0;
  logic [3:0]  pstb;
  logic        ready;
  logic        slave_en = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  apb_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .APB_PCLK(clk), .APB_PRESET(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_write(m0_write),
    .m0_strb(m0_strb), .m0_done(m0_done), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_write(m1_write),
    .m1_strb(m1_strb), .m1_done(m1_done), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .paddr(paddr), .pdata(pdata), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pstb(pstb), .prdata(prdata), .ready(ready), .perr(perr)
  );

  // Slave raises ready one cycle after it sees psel & penable
  always @(posedge clk or posedge rst) begin
    if (rst) ready <= 1'b0;
    else     ready <= slave_en && psel && penable && !ready;
  end

  int          psel_cycles = 0, pen_cycles = 0, m0_dones = 0, m1_dones = 0;
  logic [31:0] acc_addr = 0, acc_wdata = 0;
  logic        acc_write = 0;
  logic [3:0]  acc_strb = 0;

  always @(negedge clk) begin
    if (psel) psel_cycles++;
    if (psel && penable) begin
      pen_cycles++;
      acc_addr  = paddr;
      acc_wdata = pdata;
      acc_write = pwrite;
      acc_strb  = pstb;
    end
    if (m0_done) m0_dones++;
    if (m1_done) m1_dones++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // port 0/1 waits for that port, 2 for either; who = -1 if the budget expires
  task automatic wait_done(input int port, output int who, output int cycles);
    who = -1;
    cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      cycles++;
      if (m0_done && port != 1) begin who = 0; return; end
      if (m1_done && port != 0) begin who = 1; return; end
    end
  endtask

  int who, cyc, p0, e0, d0, d1;

  initial begin
    #2;
    chk("rst_psel",    32'(psel), 0);
    chk("rst_penable", 32'(penable), 0);
    chk("rst_pwrite",  32'(pwrite), 0);
    chk("rst_paddr",   paddr, 0);
    chk("rst_pdata",   pdata, 0);
    chk("rst_pstb",    32'(pstb), 0);
    chk("rst_done",    32'({m0_done, m1_done}), 0);
    chk("rst_rdata",   m0_rdata | m1_rdata, 0);
    chk("rst_err",     32'({m0_err, m1_err}), 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    // Single write from m0 to the UART
    p0 = psel_cycles; e0 = pen_cycles; d0 = m0_dones; d1 = m1_dones;
    m0_addr = 32'h1000_0000; m0_wdata = 32'h41; m0_write = 1; m0_strb = 4'hF; m0_req = 1;
    wait_done(0, who, cyc);
    chk("wr_who", who, 0);
    chk("wr_latency", cyc, 4);
    chk("wr_err", 32'(m0_err), 0);
    m0_req = 0;
    @(negedge clk); #1;
    chk("wr_done_pulse", 32'(m0_done), 0);
    chk("wr_psel_cycles", psel_cycles - p0, 3);
    chk("wr_pen_cycles", pen_cycles - e0, 2);
    chk("wr_pwrite", 32'(acc_write), 1);
    chk("wr_pstb", 32'(acc_strb), 32'hF);
    chk("wr_paddr", acc_addr, 32'h1000_0000);
    chk("wr_pdata", acc_wdata, 32'h41);
    chk("wr_m0_dones", m0_dones - d0, 1);
    chk("wr_m1_dones", m1_dones - d1, 0);

    // Read by m1
    d0 = m0_dones;
    m1_addr = 32'h1000_0005; m1_write = 0; m1_strb = 4'hF; prdata = 32'h61; m1_req = 1;
    wait_done(1, who, cyc);
    chk("rd_who", who, 1);
    chk("rd_rdata", m1_rdata, 32'h61);
    chk("rd_err", 32'(m1_err), 0);
    m1_req = 0;
    chk("rd_pstb", 32'(acc_strb), 0);
    chk("rd_paddr", acc_addr, 32'h1000_0005);
    chk("rd_m0_dones", m0_dones - d0, 0);

    // Contention from reset: expect m0, m1, m0, m1
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    m0_addr = 32'h2000_0000; m0_write = 0; prdata = 32'hAAAA_5555;
    m1_addr = 32'h3000_0000; m1_write = 1; m1_wdata = 32'h77; m1_strb = 4'h3;
    m0_req = 1; m1_req = 1;
    for (int k = 0; k < 4; k++) begin
      wait_done(2, who, cyc);
      chk("cont_order", who, k % 2);
      chk("cont_addr", acc_addr, (who == 1) ? 32'h3000_0000 : 32'h2000_0000);
      if (who == 0) m0_req = 0; else m1_req = 0;
      if (k == 3) begin
        m0_req = 0; m1_req = 0;
      end else begin
        @(negedge clk);
        if (who == 0) m0_req = 1; else m1_req = 1;
      end
    end
    chk("cont_m0_rdata", m0_rdata, 32'hAAAA_5555);
    @(negedge clk);

    // Timeout: slave never answers
    slave_en = 0; prdata = 32'h55;
    e0 = pen_cycles;
    m0_addr = 32'h1000_0008; m0_write = 0; m0_req = 1;
    wait_done(0, who, cyc);
    chk("to_who", who, 0);
    chk("to_err", 32'(m0_err), 1);
    chk("to_rdata", m0_rdata, 0);
    chk("to_access_cycles", pen_cycles - e0, 4);
    m0_req = 0; slave_en = 1;
    @(negedge clk); #1;
    chk("to_psel_low", 32'(psel), 0);
    m1_addr = 32'h1000_0010; m1_write = 1; m1_wdata = 32'h5A; m1_strb = 4'hF; m1_req = 1;
    wait_done(1, who, cyc);
    chk("after_to_who", who, 1);
    chk("after_to_err", 32'(m1_err), 0);
    m1_req = 0;
    @(negedge clk);

    // Reset during ACCESS
    m1_addr = 32'h1000_0014; m1_write = 0; m1_req = 1;
    who = 0;
    for (int i = 0; i < 10 && who == 0; i++) begin
      @(negedge clk); #1;
      if (psel && penable) who = 1;
    end
    chk("rst_mid_reached_access", who, 1);
    d0 = m0_dones; d1 = m1_dones;
    rst = 1; #1;
    chk("rst_mid_psel", 32'(psel), 0);
    chk("rst_mid_penable", 32'(penable), 0);
    m1_req = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_mid_no_done", (m0_dones - d0) + (m1_dones - d1), 0);
    m0_addr = 32'h0000_0004; m0_write = 0; m1_addr = 32'h0000_0008; m1_write = 0;
    m0_req = 1; m1_req = 1;
    wait_done(2, who, cyc);
    chk("rst_tie_who", who, 0);
    m0_req = 0;
    wait_done(1, who, cyc);
    chk("rst_tie_second", who, 1);
    m1_req = 0;
    @(negedge clk);

    // Slave error on an m1 write
    perr = 1;
    m1_addr = 32'h1000_0020; m1_write = 1; m1_wdata = 32'h1; m1_req = 1;
    wait_done(1, who, cyc);
    chk("serr_who", who, 1);
    chk("serr_err", 32'(m1_err), 1);
    m1_req = 0; perr = 0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
